// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave: accepts one request, waits a fixed
// number of cycles, then returns a single-cycle ack with read data / error.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic        ack,
   output logic [31:0] readData,
   output logic        err,
   output logic        busy
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [31:0]      mem [DEPTH_WORDS];

   logic [1:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             lat_we;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;

   logic             accept;
   logic             enter_resp;
   logic             txn_we;
   logic [31:0]      txn_addr;
   logic [31:0]      txn_wdata;
   logic             addr_err;
   logic [IDX_W-1:0] idx;
   logic             mem_we;
   logic             ack_nx;
   logic [31:0]      rdata_nx;
   logic             err_nx;
   logic             busy_nx;

   // Transaction fields: live inputs on the accept edge, latched copy afterwards
   always_comb begin
      txn_we    = lat_we;
      txn_addr  = lat_addr;
      txn_wdata = lat_wdata;
      if (state == S_IDLE) begin
         txn_we    = we;
         txn_addr  = address;
         txn_wdata = writeData;
      end
   end

   // Range/alignment check; the word index is only formed once the check passes
   always_comb begin
      addr_err = (txn_addr[1:0] != 2'b00) ||
                 (txn_addr[31:2] >= 30'(DEPTH_WORDS));
      idx      = '0;
      if (!addr_err) begin
         idx = txn_addr[IDX_W+1:2];
      end
   end

   // Next-state, counter and registered-output next values
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      ack_nx     = 1'b0;
      rdata_nx   = '0;
      err_nx     = 1'b0;
      mem_we     = 1'b0;

      case (state)
         S_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nx   = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_nx   = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_RESP: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase

      if (enter_resp) begin
         ack_nx = 1'b1;
         err_nx = addr_err;
         mem_we = !addr_err && txn_we;
         if (!addr_err && !txn_we) begin
            rdata_nx = mem[idx];
         end
      end

      busy_nx = (state_nx != S_IDLE);
   end

   // State, counter, request latch and output registers
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         ack       <= 1'b0;
         readData  <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         ack      <= ack_nx;
         readData <= rdata_nx;
         err      <= err_nx;
         busy     <= busy_nx;
         if (accept) begin
            lat_we    <= we;
            lat_addr  <= address;
            lat_wdata <= writeData;
         end
      end
   end

   // Storage array: committed on the edge entering RESP, never cleared by reset
   always_ff @(posedge clock_in) begin
      if (mem_we) begin
         mem[idx] <= txn_wdata;
      end
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words stored; power of two, 4 to 1024.
REQ-002 Parameter WAIT_STATES, default 2: wait cycles between accept and response; range 0 to 15.
REQ-003 clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  core request strobe; the core holds it until ack.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 address  input  32  byte address; only word-aligned addresses are legal.
REQ-008 writeData  input  32  store data; sampled with req.
REQ-009 ack  output  1  one-cycle response strobe; completes the transaction.
REQ-010 readData  output  32  read result; valid only while ack=1.
REQ-011 err  output  1  error flag; valid only while ack=1.
REQ-012 busy  output  1  high from accept until the cycle after ack.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, the block SHALL accept the request: latch we, address and writeData, and set busy=1 on the next edge.
REQ-015 On accept, the block SHALL go to WAIT, loading a counter with WAIT_STATES-1; if WAIT_STATES=0 it SHALL go directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-017 Accept-to-ack latency SHALL be exactly WAIT_STATES+1 cycles; the ack cycle is the cycle after the last wait cycle.
REQ-018 In RESP, the block SHALL drive ack=1 for exactly one cycle, then return to IDLE.
REQ-019 From that IDLE state, the block SHALL accept a new req on the first IDLE cycle (back-to-back throughput of 1 per WAIT_STATES+2 cycles).
REQ-020 Input changes on req, we, address or writeData after accept SHALL be ignored until the next IDLE.
REQ-021 Dropping req before ack SHALL NOT abort the transaction; it completes normally.
REQ-022 Error condition: address[1:0]!=0, or address[31:2] >= DEPTH_WORDS; it is evaluated on the latched address.
REQ-023 Legal write: the array word at address[31:2] SHALL be updated on the edge entering RESP; readData=0 and err=0 during ack.
REQ-024 Legal read: readData SHALL equal the array word at address[31:2], with err=0 during ack.
REQ-025 Errored request: no array write; readData=0 and err=1 during ack.
REQ-026 A read following a write to the same word SHALL return the new data.
REQ-027 Outside ack, readData and err SHALL be 0.
REQ-028 Address arithmetic SHALL use bits [log2(DEPTH_WORDS)+1:2] for indexing, but only after the range check has passed.

Reset
REQ-029 reset=0 SHALL force IDLE, ack=0, err=0, readData=0, busy=0, and counter=0 immediately, without waiting for a clock edge.
REQ-030 A reset asserted during WAIT or RESP SHALL abandon the transaction; a pending write not yet committed SHALL be discarded.
REQ-031 Array contents SHALL NOT be cleared by reset; their contents are undefined after power-up.
REQ-032 After reset deasserts, the first rising edge with req=1 SHALL accept a request.

Verification
REQ-033 WAIT_STATES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> ack 3 cycles after each accept; readData=0xDEADBEEF, err=0.
REQ-034 Misaligned write to 0x13 with 0x12345678, then read 0x10 -> first ack has err=1; the read returns the prior value unchanged.
REQ-035 DEPTH_WORDS=64: read 0x100 -> err=1, readData=0, ack after 3 cycles.
REQ-036 WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 with req held high -> ack on cycles 1 and 3; busy toggles as specified.
REQ-037 Assert reset one cycle after accepting a write of 0xA5A5A5A5 to 0x8 -> ack never asserts; a later read of 0x8 returns the old value.
REQ-038 Change address and writeData during WAIT -> the response reflects the originally latched values only.
